victory_scorer: RTL and testbench
=================================

Name: victory_scorer

Overview:
- Downstream stage of the tug-of-war playfield. Watches the two end lights and the conditioned player presses, and detects a round win.
- On a win it increments that player's score and holds the playfield in reset for a fixed display window.
- Drives one active-low 7-segment digit per player and a game-over flag once either score reaches the target.

Parameters:
- MAX_SCORE, 7, winning score; legal range 1..9; game ends when a score equals it.
- HOLD_CYCLES, 4, cycles roundReset stays high after each round win (≥1).
- CW, $clog2(MAX_SCORE+1), score counter width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- L  in  1  left player press, single-cycle pulse, already synchronized and edge-detected.
- R  in  1  right player press, same conditioning as L.
- leftEnd  in  1  leftmost playfield light is on.
- rightEnd  in  1  rightmost playfield light is on.
- roundReset  out  1  reset to playfield lights (OR'd with system reset externally).
- scoreL  out  CW  left player score.
- scoreR  out  CW  right player score.
- hexL  out  7  active-low segments {g..a} showing scoreL.
- hexR  out  7  active-low segments {g..a} showing scoreR.
- gameOver  out  1  a player has reached MAX_SCORE.

Behaviour:
- Clocking and reset: one clock, single rising-edge domain. Reset is asynchronous and active-high. Every output is registered or derived combinationally from registers only.
- Reset values: state=PLAY, scoreL=scoreR=0, holdCnt=0, roundReset=0, gameOver=0, hexL=hexR=7'b1000000 ("0").
- States: PLAY, HOLD, OVER.
- PLAY, left win: leftEnd & L & ~R is sampled at an edge. At that edge scoreL+=1, holdCnt loads HOLD_CYCLES-1, state goes to HOLD, roundReset goes to 1.
- PLAY, right win: rightEnd & R & ~L, handled symmetrically with scoreR.
- PLAY, simultaneous press: L & R in the same cycle cancels. No win, no change, even if an end light is on.
- PLAY, both end lights on: treated as a playfield fault. Only the press condition above decides; with a single press, the matching rule applies.
- HOLD: roundReset=1 for exactly HOLD_CYCLES cycles, counted from the edge after the win edge. holdCnt decrements each cycle; L, R, leftEnd and rightEnd are ignored.
- HOLD exit: when holdCnt==0, the next edge goes to OVER if either score==MAX_SCORE, otherwise to PLAY with roundReset=0.
- OVER: roundReset=1 and gameOver=1, held until reset; scores frozen. gameOver rises on the same edge state enters OVER.
- Score arithmetic: unsigned, CW bits. A score never exceeds MAX_SCORE because a win can only occur in PLAY, so no wrap is possible.
- Display: hexL/hexR are a combinational decode of the registered scores, using standard active-low digit codes 0-9. Any value >9 shows blank (7'b1111111) as a defensive default.
- Reset mid-HOLD or in OVER: immediate return to the reset values, independent of the clock.

Decomposition:
- Package victory_pkg holds:
  - the state enum typedef {PLAY, HOLD, OVER};
  - localparam SEG_BLANK = 7'b1111111;
  - a constant array of the ten active-low digit codes.
- One sub-module, seg7_digit: combinational 4-bit→7-segment decoder, instantiated twice.
- FSM, hold counter and score registers stay in victory_scorer.

Test Plan:
- Reset, then leftEnd=1 with L=1 for one cycle → next cycle scoreL=1, hexL=7'b1111001, roundReset=1 for exactly 4 cycles, then 0 with state PLAY.
- rightEnd=1, L=1, R=1 in the same cycle → no score change, roundReset stays 0. Then R alone → scoreR=1.
- leftEnd=0 with L pulses for 10 cycles → scoreL unchanged at 0, roundReset=0.
- Left wins seven rounds (MAX_SCORE=7), each with a 4-cycle hold → after the 7th hold, gameOver=1, roundReset=1, hexL=7'b1111000. Further presses leave scores at 7/0.
- Assert reset during the 2nd cycle of HOLD, asynchronously between edges → outputs return to reset values immediately; the next left win proceeds normally from scoreL=0.
- Presses arriving during HOLD (rightEnd=1, R=1 in hold cycle 2) → ignored; scoreR unchanged.

Source files
------------

// File: rtl/victory_pkg.sv
// Shared types and constants for the tug-of-war victory scorer.
package victory_pkg;

    // Scorer FSM states.
    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } state_t;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} codes for digits 0..9.
    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/victory_scorer_seg7.sv
// Combinational 4-bit to active-low 7-segment decoder; values above 9 blank.
module seg7_digit
    import victory_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Look up the digit code, blank anything outside 0..9.
    always_comb begin
        seg = SEG_BLANK;
        if (digit < 4'd10) begin
            seg = SEG_DIGITS[digit];
        end
    end

endmodule

// File: rtl/victory_scorer.sv
// Detects round wins on the tug-of-war playfield, keeps both scores, holds
// the playfield in reset for a display window after each win, and latches
// game over once a player reaches MAX_SCORE.
//
// Handshake: none. L and R are single-cycle qualified pulses that are only
// acted on in PLAY; there is no ready/backpressure, so presses outside PLAY
// are simply dropped.
module victory_scorer
    import victory_pkg::*;
#(
    parameter  int MAX_SCORE   = 7,
    parameter  int HOLD_CYCLES = 4,
    localparam int CW          = $clog2(MAX_SCORE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          L,
    input  logic          R,
    input  logic          leftEnd,
    input  logic          rightEnd,
    output logic          roundReset,
    output logic [CW-1:0] scoreL,
    output logic [CW-1:0] scoreR,
    output logic [6:0]    hexL,
    output logic [6:0]    hexR,
    output logic          gameOver,
    output state_t        dbg_state
);

    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] MAX_C     = CW'(MAX_SCORE);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] score_l_q, score_l_d;
    logic [CW-1:0] score_r_q, score_r_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          round_reset_q, round_reset_d;
    logic          game_over_q, game_over_d;

    // Next-state logic: win detection in PLAY, countdown in HOLD, latch in OVER.
    always_comb begin
        state_d       = state_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        hold_cnt_d    = hold_cnt_q;
        round_reset_d = round_reset_q;
        game_over_d   = game_over_q;
        case (state_q)
            PLAY: begin
                // A simultaneous press cancels; each win also needs its own end light.
                if (L && !R && leftEnd) begin
                    score_l_d     = score_l_q + 1'b1;
                    hold_cnt_d    = HOLD_LOAD;
                    state_d       = HOLD;
                    round_reset_d = 1'b1;
                end else if (R && !L && rightEnd) begin
                    score_r_d     = score_r_q + 1'b1;
                    hold_cnt_d    = HOLD_LOAD;
                    state_d       = HOLD;
                    round_reset_d = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    if (score_l_q == MAX_C || score_r_q == MAX_C) begin
                        state_d       = OVER;
                        round_reset_d = 1'b1;
                        game_over_d   = 1'b1;
                    end else begin
                        state_d       = PLAY;
                        round_reset_d = 1'b0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            OVER: begin
                round_reset_d = 1'b1;
                game_over_d   = 1'b1;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
    end

    // State, score and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= PLAY;
            score_l_q     <= '0;
            score_r_q     <= '0;
            hold_cnt_q    <= '0;
            round_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            hold_cnt_q    <= hold_cnt_d;
            round_reset_q <= round_reset_d;
            game_over_q   <= game_over_d;
        end
    end

    logic [3:0] digit_l;
    logic [3:0] digit_r;

    // Widen the score registers to the decoder's 4-bit input.
    always_comb begin
        digit_l = 4'(score_l_q);
        digit_r = 4'(score_r_q);
    end

    seg7_digit u_seg_l (.digit(digit_l), .seg(hexL));
    seg7_digit u_seg_r (.digit(digit_r), .seg(hexR));

    assign roundReset = round_reset_q;
    assign gameOver   = game_over_q;
    assign scoreL     = score_l_q;
    assign scoreR     = score_r_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_victory_scorer.sv
// Self-checking bench for victory_scorer: directed scenarios plus random
// play, compared every cycle against a round-level behavioural model.
module tb_victory_scorer;
    import victory_pkg::*;

    localparam int MAX_SCORE   = 7;
    localparam int HOLD_CYCLES = 4;
    localparam int CW          = $clog2(MAX_SCORE + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          L = 1'b0;
    logic          R = 1'b0;
    logic          leftEnd = 1'b0;
    logic          rightEnd = 1'b0;
    logic          roundReset;
    logic [CW-1:0] scoreL;
    logic [CW-1:0] scoreR;
    logic [6:0]    hexL;
    logic [6:0]    hexR;
    logic          gameOver;
    state_t        dbg_state;

    int checks = 0;
    int errors = 0;

    victory_scorer #(.MAX_SCORE(MAX_SCORE), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk(clk), .reset(reset), .L(L), .R(R),
        .leftEnd(leftEnd), .rightEnd(rightEnd),
        .roundReset(roundReset), .scoreL(scoreL), .scoreR(scoreR),
        .hexL(hexL), .hexR(hexR), .gameOver(gameOver), .dbg_state(dbg_state)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, ...
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Active-low digit patterns, written independently from the display table.
    function automatic int seg_of(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    // Round-level model: hold_rem counts display cycles still owed.
    int m_sl = 0;
    int m_sr = 0;
    int m_hold = 0;
    bit m_over = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_sl   <= 0;
            m_sr   <= 0;
            m_hold <= 0;
            m_over <= 1'b0;
        end else if (m_over) begin
            m_over <= 1'b1;
        end else if (m_hold > 0) begin
            m_hold <= m_hold - 1;
            if (m_hold == 1 && (m_sl == MAX_SCORE || m_sr == MAX_SCORE)) m_over <= 1'b1;
        end else if (L && !R && leftEnd) begin
            m_sl   <= m_sl + 1;
            m_hold <= HOLD_CYCLES;
        end else if (R && !L && rightEnd) begin
            m_sr   <= m_sr + 1;
            m_hold <= HOLD_CYCLES;
        end
    end

    // Compare process: every falling edge out of reset.
    always @(negedge clk) begin
        if (!reset) begin
            chk("scoreL", int'(scoreL), m_sl);
            chk("scoreR", int'(scoreR), m_sr);
            chk("hexL", int'(hexL), seg_of(m_sl));
            chk("hexR", int'(hexR), seg_of(m_sr));
            chk("roundReset", int'(roundReset), int'(m_over || m_hold > 0));
            chk("gameOver", int'(gameOver), int'(m_over));
            chk("state", int'(dbg_state),
                m_over ? int'(OVER) : (m_hold > 0 ? int'(HOLD) : int'(PLAY)));
        end
    end

    // Drive one cycle of inputs, applied just after the falling edge.
    task automatic cyc(input logic l, input logic r, input logic le, input logic re);
        @(negedge clk);
        #1;
        L = l; R = r; leftEnd = le; rightEnd = re;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Synchronous-style reset pulse with reset-value checks.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1; L = 1'b0; R = 1'b0; leftEnd = 1'b0; rightEnd = 1'b0;
        @(negedge clk);
        chk("rst_scoreL", int'(scoreL), 0);
        chk("rst_hexL", int'(hexL), 7'b1000000);
        chk("rst_hexR", int'(hexR), 7'b1000000);
        chk("rst_roundReset", int'(roundReset), 0);
        chk("rst_gameOver", int'(gameOver), 0);
        #1;
        reset = 1'b0;
    endtask

    int rr_cnt;

    initial begin
        do_reset();

        // First left win: score, display and exact hold length.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        rr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("win1_scoreL", int'(scoreL), 1);
                chk("win1_hexL", int'(hexL), 7'b1111001);
            end
            if (roundReset) rr_cnt++;
            #1;
            L = 1'b0; leftEnd = 1'b0;
        end
        chk("hold_len", rr_cnt, 4);
        chk("after_hold_state", int'(dbg_state), int'(PLAY));

        // Simultaneous press cancels, then R alone wins.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        idle(2);
        chk("cancel_scoreR", int'(scoreR), 0);
        chk("cancel_rr", int'(roundReset), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("rwin_scoreR", int'(scoreR), 1);
        idle(6);

        // Presses without the end light do nothing.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("noend_scoreL", int'(scoreL), 0);
        chk("noend_rr", int'(roundReset), 0);

        // Seven left wins end the game; press R during hold cycle 2 of each.
        do_reset();
        for (int w = 0; w < MAX_SCORE; w++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
            idle(4);
        end
        chk("over_scoreR", int'(scoreR), 0);
        chk("over_gameOver", int'(gameOver), 1);
        chk("over_rr", int'(roundReset), 1);
        chk("over_hexL", int'(hexL), 7'b1111000);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        idle(1);
        chk("frozen_scoreL", int'(scoreL), 7);
        chk("frozen_scoreR", int'(scoreR), 0);

        // Asynchronous reset in hold cycle 2, between edges.
        do_reset();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_async_rr", int'(roundReset), 1);
        reset = 1'b1;
        #1;
        chk("async_scoreL", int'(scoreL), 0);
        chk("async_rr", int'(roundReset), 0);
        chk("async_hexL", int'(hexL), 7'b1000000);
        chk("async_state", int'(dbg_state), int'(PLAY));
        @(negedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        chk("post_async_scoreL", int'(scoreL), 1);
        idle(6);

        // Random play against the model, several games.
        for (int g = 0; g < 6; g++) begin
            do_reset();
            for (int i = 0; i < 250; i++) begin
                cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0));
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
